// File: rtl/id_word_serializer.sv
// id_word_serializer: splits buffered IDs into a low/high 32-bit word stream.
// Optional macro SER_TAG_EN puts a sequence tag in the unused high-word bits.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   id_in/id_valid/    ID input handshake (2-entry FIFO behind it)
//   id_ready
//   data_out/valid_out word output handshake, low word then high word
//   ready_in
//   sent_count         IDs whose high word has been accepted
//   done               sticky, set once NUM_ID IDs are sent
module id_word_serializer #(
   parameter int ID_W   = 50,
   parameter int NUM_ID = 1000,
   parameter int CNT_W  = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [ID_W-1:0]  id_in,
   input  logic             id_valid,
   output logic             id_ready,
   output logic [31:0]      data_out,
   output logic             valid_out,
   input  logic             ready_in,
   output logic [CNT_W-1:0] sent_count,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE, LO, HI, DONE
   } state_t;

   state_t          state;
   logic [ID_W-1:0] mem [2];
   logic            wr_ptr;
   logic            rd_ptr;
   logic [1:0]      count;
   logic [ID_W-1:0] cur_id;
   logic [ID_W-1:0] head;
   logic            push;
   logic            pop;
   logic            hs;
   logic            last;
   logic [31:0]     hi_word;

   assign head     = mem[rd_ptr];
   assign id_ready = (count != 2'd2) && (state != DONE);
   assign push     = id_valid && id_ready;
   assign hs       = valid_out && ready_in;
   assign last     = (sent_count == CNT_W'(NUM_ID - 1));

   // Head leaves the FIFO when IDLE sees data, or when
   // a high word completes and more IDs are waiting.
   always_comb begin
      pop = 1'b0;
      unique case (1'b1)
         state == IDLE: pop = (count != 2'd0);
         state == HI:   pop = hs && !last && (count != 2'd0);
         default:       pop = 1'b0;
      endcase
   end

   // Tag is the pre-increment sent_count; bits past
   // the word boundary fall off in the 32-bit cast.
   always_comb begin
      hi_word = 32'(cur_id >> 32);
`ifdef SER_TAG_EN
      hi_word = hi_word
              | 32'(64'(sent_count) << (ID_W - 32));
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= id_in;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         unique case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cur_id     <= '0;
         data_out   <= '0;
         valid_out  <= 1'b0;
         sent_count <= '0;
         done       <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pop) begin
                  cur_id    <= head;
                  data_out  <= head[31:0];
                  valid_out <= 1'b1;
                  state     <= LO;
               end
            end
            LO: begin
               if (hs) begin
                  data_out <= hi_word;
                  state    <= HI;
               end
            end
            HI: begin
               if (hs) begin
                  sent_count <= sent_count + 1'b1;
                  if (last) begin
                     valid_out <= 1'b0;
                     data_out  <= '0;
                     done      <= 1'b1;
                     state     <= DONE;
                  end else if (pop) begin
                     cur_id   <= head;
                     data_out <= head[31:0];
                     state    <= LO;
                  end else begin
                     valid_out <= 1'b0;
                     state     <= IDLE;
                  end
               end
            end
            DONE: begin
               valid_out <= 1'b0;
               done      <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
